// File: rtl/deadlock_kernel_monitor_multi_if.sv
// Signal bundle between a kernel and its deadlock monitor: block indicators in,
// detection level/pulse and captured diagnosis out.
interface deadlock_kernel_monitor_multi_if #(
    parameter int NUM_AXIS = 1,
    parameter int NUM_INST = 2,
    parameter int CNT_W    = 8
);
    localparam int IDX_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;

    logic                enable;
    logic                diag_clear;
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_INST-1:0] inst_idle_sigs;
    logic [NUM_INST-1:0] inst_block_sigs;
    logic                block;
    logic                block_rise;
    logic [NUM_AXIS-1:0] blocked_axis_mask;
    logic [IDX_W-1:0]    first_axis_idx;
    logic                diag_valid;
    logic [CNT_W-1:0]    block_count;

    modport master (
        output enable, diag_clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, block_rise, blocked_axis_mask, first_axis_idx, diag_valid, block_count
    );

    modport slave (
        input  enable, diag_clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, block_rise, blocked_axis_mask, first_axis_idx, diag_valid, block_count
    );
endinterface

// File: rtl/deadlock_kernel_monitor_multi.sv
// Per-kernel deadlock detector: declares a deadlock once the stalled-but-not-finished
// condition persists THRESHOLD cycles, and keeps a sticky diagnosis of the last event.
module deadlock_kernel_monitor_multi #(
    parameter int NUM_AXIS  = 1,
    parameter int NUM_INST  = 2,
    parameter int THRESHOLD = 4,
    parameter int CNT_W     = 8
) (
    input  logic                              kernel_monitor_clock,
    input  logic                              kernel_monitor_reset,
    deadlock_kernel_monitor_multi_if.slave    mon
);
    localparam int IDX_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int RUN_W = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, BLOCKED} state_t;

    state_t              state, state_next;
    logic [RUN_W-1:0]    run, run_next;
    logic                cand;
    logic                entry;
    logic                stay;
    logic                block_q;
    logic                rise_q;
    logic [NUM_AXIS-1:0] mask_q;
    logic                valid_q;
    logic [CNT_W-1:0]    count_q;
    logic [IDX_W-1:0]    idx;

    // Stalled somewhere, every instance idle or blocked, but not all idle (that is "done").
    assign cand = mon.enable
                & (|mon.axis_block_sigs)
                & (&(mon.inst_idle_sigs | mon.inst_block_sigs))
                & ~(&mon.inst_idle_sigs);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_next = state;
        run_next   = run;
        case (state)
            IDLE: begin
                if (cand) begin
                    if (THRESHOLD == 1) begin
                        state_next = BLOCKED;
                    end else begin
                        state_next = COUNT;
                        run_next   = RUN_W'(1);
                    end
                end
            end
            COUNT: begin
                if (!cand) begin
                    state_next = IDLE;
                    run_next   = '0;
                end else if (run == RUN_W'(THRESHOLD - 1)) begin
                    state_next = BLOCKED;
                    run_next   = '0;
                end else begin
                    run_next = run + RUN_W'(1);
                end
            end
            BLOCKED: begin
                if (!cand) begin
                    state_next = IDLE;
                    run_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                run_next   = '0;
            end
        endcase
    end

    assign entry = (state_next == BLOCKED) && (state != BLOCKED);
    assign stay  = (state_next == BLOCKED) && (state == BLOCKED);

    always_ff @(posedge kernel_monitor_clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (kernel_monitor_reset) begin
            state   <= IDLE;
            run     <= '0;
            block_q <= 1'b0;
            rise_q  <= 1'b0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            run     <= run_next;
            block_q <= (state_next == BLOCKED);
            rise_q  <= entry;

            // A new event replaces the old diagnosis and beats a coincident clear.
            if (entry) begin
                mask_q  <= mon.axis_block_sigs;
                valid_q <= 1'b1;
            end else if (mon.diag_clear) begin
                mask_q  <= '0;
                valid_q <= 1'b0;
            end else if (stay) begin
                mask_q  <= mask_q | mon.axis_block_sigs;
            end

            if (entry) begin
                if (mon.diag_clear)
                    count_q <= CNT_W'(1);
                else if (count_q != {CNT_W{1'b1}})
                    count_q <= count_q + CNT_W'(1);
            end else if (mon.diag_clear) begin
                count_q <= '0;
            end
        end
    end

    // Lowest blocked channel wins; scanning downward lets the lowest index overwrite.
    always_comb begin
        idx = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (mask_q[i]) idx = IDX_W'(i);
        end
    end

    assign mon.block             = block_q;
    assign mon.block_rise        = rise_q;
    assign mon.blocked_axis_mask = mask_q;
    assign mon.first_axis_idx    = idx;
    assign mon.diag_valid        = valid_q;
    assign mon.block_count       = count_q;
endmodule

// File: tb/tb_deadlock_kernel_monitor_multi.sv
// Drives two monitors (THRESHOLD=4/CNT_W=2 and THRESHOLD=1/CNT_W=8) with one stimulus
// stream and compares both against a run-length reference model every cycle.
module tb_deadlock_kernel_monitor_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic       en, clr;
    logic [2:0] axis;
    logic [1:0] idle, iblk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    deadlock_kernel_monitor_multi_if #(.NUM_AXIS(3), .NUM_INST(2), .CNT_W(2)) if0 ();
    deadlock_kernel_monitor_multi_if #(.NUM_AXIS(3), .NUM_INST(2), .CNT_W(8)) if1 ();

    assign if0.enable = en;   assign if1.enable = en;
    assign if0.diag_clear = clr;  assign if1.diag_clear = clr;
    assign if0.axis_block_sigs = axis;  assign if1.axis_block_sigs = axis;
    assign if0.inst_idle_sigs = idle;   assign if1.inst_idle_sigs = idle;
    assign if0.inst_block_sigs = iblk;  assign if1.inst_block_sigs = iblk;

    deadlock_kernel_monitor_multi #(.NUM_AXIS(3), .NUM_INST(2), .THRESHOLD(4), .CNT_W(2)) dut0 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .mon(if0));
    deadlock_kernel_monitor_multi #(.NUM_AXIS(3), .NUM_INST(2), .THRESHOLD(1), .CNT_W(8)) dut1 (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .mon(if1));

    // Reference: deadlock = cand has held for at least THRESHOLD consecutive edges.
    int         th[2]   = '{4, 1};
    int         cmax[2] = '{3, 255};
    int         m_run[2];
    bit         m_blk[2], m_rise[2], m_valid[2];
    logic [2:0] m_mask[2];
    int         m_count[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [2:0] m);
        for (int i = 0; i < 3; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic model_update();
        bit c, nb, ent;
        int nr;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_run[d] = 0; m_blk[d] = 0; m_rise[d] = 0;
                m_mask[d] = '0; m_valid[d] = 0; m_count[d] = 0;
            end else begin
                c   = en && (axis != 0) && ((idle | iblk) == 2'b11) && (idle != 2'b11);
                nr  = c ? ((m_run[d] < 100000) ? m_run[d] + 1 : m_run[d]) : 0;
                nb  = (nr >= th[d]);
                ent = nb && !m_blk[d];
                if (ent)              m_mask[d] = axis;
                else if (clr)         m_mask[d] = '0;
                else if (nb)          m_mask[d] = m_mask[d] | axis;
                if (ent)              m_valid[d] = 1;
                else if (clr)         m_valid[d] = 0;
                if (ent)              m_count[d] = clr ? 1 : ((m_count[d] < cmax[d]) ? m_count[d] + 1 : m_count[d]);
                else if (clr)         m_count[d] = 0;
                m_rise[d] = ent;
                m_blk[d]  = nb;
                m_run[d]  = nr;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic b, input logic r, input logic [2:0] m,
                             input logic [1:0] ix, input logic v, input logic [7:0] cnt);
        check($sformatf("dut%0d_block", d), 32'(b), 32'(m_blk[d]));
        check($sformatf("dut%0d_rise", d), 32'(r), 32'(m_rise[d]));
        check($sformatf("dut%0d_mask", d), 32'(m), 32'(m_mask[d]));
        check($sformatf("dut%0d_idx", d), 32'(ix), 32'(lowest(m_mask[d])));
        check($sformatf("dut%0d_valid", d), 32'(v), 32'(m_valid[d]));
        check($sformatf("dut%0d_count", d), 32'(cnt), 32'(m_count[d]));
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [2:0] a,
                        input logic [1:0] il, input logic [1:0] bl);
        rst = r; en = e; clr = c; axis = a; idle = il; iblk = bl;
        @(posedge clk);
        cycle++;
        model_update();
        @(negedge clk);
        check_dut(0, if0.block, if0.block_rise, if0.blocked_axis_mask, if0.first_axis_idx,
                  if0.diag_valid, {6'b0, if0.block_count});
        check_dut(1, if1.block, if1.block_rise, if1.blocked_axis_mask, if1.first_axis_idx,
                  if1.diag_valid, if1.block_count);
    endtask

    // Convenience: enabled, no clear, stalled stream pattern a with one idle + one blocked instance.
    task automatic stall(input logic [2:0] a);
        step(1'b0, 1'b1, 1'b0, a, 2'b01, 2'b10);
    endtask

    initial begin
        // Reset with unknown inputs
        step(1'b1, 1'bx, 1'bx, 3'bxxx, 2'bxx, 2'bxx);
        step(1'b1, 1'bx, 1'bx, 3'bxxx, 2'bxx, 2'bxx);
        check("rst_block0", 32'(if0.block), 32'd0);
        check("rst_count0", 32'(if0.block_count), 32'd0);

        // Persistent stall: block after the 4th edge, single pulse
        for (int i = 0; i < 3; i++) stall(3'b100);
        check("t1_pre_block0", 32'(if0.block), 32'd0);
        stall(3'b100);
        check("t1_block0", 32'(if0.block), 32'd1);
        check("t1_rise0", 32'(if0.block_rise), 32'd1);
        stall(3'b100);
        check("t1_rise_once0", 32'(if0.block_rise), 32'd0);
        stall(3'b100);
        check("t1_mask0", 32'(if0.blocked_axis_mask), 32'b100);
        check("t1_idx0", 32'(if0.first_axis_idx), 32'd2);
        check("t1_count0", 32'(if0.block_count), 32'd1);

        // Short stall must not declare; counter restarts
        step(1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10);
        check("t2_fall0", 32'(if0.block), 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10);
        for (int i = 0; i < 3; i++) stall(3'b100);
        step(1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10);
        check("t2_short_block0", 32'(if0.block), 32'd0);
        check("t2_short_count0", 32'(if0.block_count), 32'd1);
        for (int i = 0; i < 4; i++) stall(3'b100);
        check("t2_restart_block0", 32'(if0.block), 32'd1);

        // Mask accumulates while blocked, holds after exit
        stall(3'b011);
        stall(3'b011);
        step(1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00);
        check("t3_fall0", 32'(if0.block), 32'd0);
        check("t3_mask0", 32'(if0.blocked_axis_mask), 32'b111);
        check("t3_idx0", 32'(if0.first_axis_idx), 32'd0);
        check("t3_valid0", 32'(if0.diag_valid), 32'd1);

        // All instances idle: finished, never a deadlock
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 3'b111, 2'b11, 2'b00);
        check("t4_finished0", 32'(if0.block), 32'd0);
        check("t4_finished1", 32'(if1.block), 32'd0);

        // Clear, then saturate a 2-bit counter, then clear coinciding with entry
        step(1'b0, 1'b1, 1'b1, 3'b000, 2'b01, 2'b10);
        check("t5_clr_count0", 32'(if0.block_count), 32'd0);
        check("t5_clr_valid0", 32'(if0.diag_valid), 32'd0);
        for (int e = 0; e < 5; e++) begin
            for (int i = 0; i < 4; i++) stall(3'b100);
            step(1'b0, 1'b1, 1'b0, 3'b000, 2'b01, 2'b10);
        end
        check("t5_sat_count0", 32'(if0.block_count), 32'd3);
        for (int i = 0; i < 3; i++) stall(3'b010);
        step(1'b0, 1'b1, 1'b1, 3'b010, 2'b01, 2'b10);
        check("t5_clr_entry_count0", 32'(if0.block_count), 32'd1);
        check("t5_clr_entry_mask0", 32'(if0.blocked_axis_mask), 32'b010);

        // Disable while blocked: block drops, diagnosis untouched
        stall(3'b001);
        step(1'b0, 1'b0, 1'b0, 3'b100, 2'b01, 2'b10);
        check("t6_dis_block0", 32'(if0.block), 32'd0);
        check("t6_dis_mask0", 32'(if0.blocked_axis_mask), 32'b011);

        // Reset mid-event, then immediate re-detection at THRESHOLD=1
        for (int i = 0; i < 4; i++) stall(3'b100);
        step(1'b1, 1'b1, 1'b0, 3'b100, 2'b01, 2'b10);
        check("t7_rst_block0", 32'(if0.block), 32'd0);
        check("t7_rst_mask0", 32'(if0.blocked_axis_mask), 32'd0);
        check("t7_rst_rise0", 32'(if0.block_rise), 32'd0);
        stall(3'b100);
        check("t7_th1_block1", 32'(if1.block), 32'd1);
        check("t7_th1_rise1", 32'(if1.block_rise), 32'd1);

        // Randomised segments held for a few cycles each
        for (int s = 0; s < 150; s++) begin
            logic       r, e, c;
            logic [2:0] a;
            logic [1:0] il, bl;
            int         hold;
            r    = ($urandom_range(0, 29) == 0);
            e    = ($urandom_range(0, 9) != 0);
            c    = ($urandom_range(0, 9) == 0);
            a    = 3'($urandom);
            il   = 2'($urandom);
            bl   = 2'($urandom);
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) step(r && h == 0, e, c && h == 0, a, il, bl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
